// File: rtl/data_memory_ws_if.sv
// Data-port bus between a CPU master and the wait-state data memory.
// Carries the request/byte-enable/write-data and the stall/read-return signals.
`timescale 1ns/1ps
interface data_memory_ws_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]             data_address;
  logic                    data_read;
  logic                    data_write;
  logic [DATA_WIDTH/8-1:0] data_byteenable;
  logic [DATA_WIDTH-1:0]   data_writedata;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   data_readdata;
  logic                    data_readdatavalid;
  logic                    data_error;

  modport master (
    output data_address, data_read, data_write, data_byteenable, data_writedata,
    input  waitrequest, data_readdata, data_readdatavalid, data_error
  );

  modport slave (
    input  data_address, data_read, data_write, data_byteenable, data_writedata,
    output waitrequest, data_readdata, data_readdatavalid, data_error
  );
endinterface

// File: rtl/data_memory_ws.sv
// Word-addressed, byte-enabled data RAM with WAIT_CYCLES stall cycles per access and registered read data.
// Optional misaligned-access fault reporting is enabled by defining DATA_MEMORY_MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module data_memory_ws #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int WAIT_CYCLES   = 0,
  parameter     RAM_INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  data_memory_ws_if.slave bus
);
  localparam int             NUM_BYTES  = DATA_WIDTH / 8;
  localparam int             DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [7:0]     WAIT_LIMIT = 8'(WAIT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    req;
  logic                    complete;
  logic                    misaligned;
  logic                    do_write;
  logic                    do_read;
  logic                    wait_req;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [DATA_WIDTH-1:0]   readdata_q;
  logic                    readdatavalid_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Upper address bits alias; the byte-offset bits only matter for the fault check.
  logic unused_addr;
  assign unused_addr = ^{bus.data_address[31:ADDR_WIDTH+2], bus.data_address[1:0]};

  assign req      = bus.data_read | bus.data_write;
  assign word_idx = bus.data_address[ADDR_WIDTH+1:2];

`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
  logic error_q;
  assign misaligned = |bus.data_address[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // A simultaneous read and write performs only the write.
  assign do_write = complete & bus.data_write & ~misaligned;
  assign do_read  = complete & bus.data_read & ~bus.data_write & ~misaligned;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_req = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_LIMIT == 8'd0) begin
            complete = 1'b1;
          end else begin
            wait_req = 1'b1;
            cnt_d    = 8'd1;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        wait_req = (cnt_q < WAIT_LIMIT);
        if (!req) begin
          // Master abandoned the request: drop it without touching memory.
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (wait_req) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          complete = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= 8'd0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      readdatavalid_q <= do_read;
      if (do_read) begin
        readdata_q <= mem[word_idx];
      end
    end
  end

`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= complete & misaligned;
    end
  end
  assign bus.data_error = error_q;
`else
  assign bus.data_error = 1'b0;
`endif

  // NOTE: the storage array has no reset; contents survive rst_n and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.data_byteenable[i]) begin
          mem[word_idx][i*8 +: 8] <= bus.data_writedata[i*8 +: 8];
        end
      end
    end
  end

  assign bus.waitrequest        = wait_req;
  assign bus.data_readdata      = readdata_q;
  assign bus.data_readdatavalid = readdatavalid_q;
endmodule
